// File: rtl/conv_sequencer.sv
// Sequencer for a 2x2 output-map convolution pass: steers accumulator position/enable per PE tap.
// Optional abort input is compiled in when CONV_SEQ_ABORT_EN is defined.
module conv_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cfg_taps,
    input  logic       p_valid,
`ifdef CONV_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       p_ready,
    output logic [2:0] ctrl,
    output logic       busy,
    output logic       out_valid,
    output logic [1:0] out_idx,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] taps;
    logic [3:0] tap_cnt;
    logic [1:0] pos;
    logic       ov_q;
    logic [1:0] idx_q;
    logic       abort_hit;
    logic       tap_acc;
    logic       last_tap;

    always_comb begin
        abort_hit = 1'b0;
`ifdef CONV_SEQ_ABORT_EN
        abort_hit = abort & ((state == ACC) | (state == FLUSH));
`endif
        tap_acc   = (state == ACC) & p_valid & ~abort_hit;
        last_tap  = tap_acc & (tap_cnt == (taps - 4'd1));

        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC: begin
                if (abort_hit)                       state_nxt = IDLE;
                else if (last_tap && (pos == 2'd3))  state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = abort_hit ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        p_ready   = (state == ACC);
        busy      = (state == ACC) | (state == FLUSH);
        ctrl      = ((state == ACC) && !abort_hit) ? {p_valid, pos} : 3'b000;
        // Result pulse is registered one cycle after the last tap; an abort squashes it.
        out_valid = ov_q & ~abort_hit;
        out_idx   = idx_q;
        done      = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            taps    <= 4'd1;
            tap_cnt <= '0;
            pos     <= '0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state <= state_nxt;
            ov_q  <= last_tap;
            if (last_tap) idx_q <= pos;
            if ((state == IDLE) && start) begin
                taps    <= (cfg_taps == 4'd0) ? 4'd1 : cfg_taps;
                tap_cnt <= '0;
                pos     <= '0;
            end else if (tap_acc) begin
                if (last_tap) begin
                    tap_cnt <= '0;
                    // Position saturates at c22 so a finished pass never wraps.
                    if (pos != 2'd3) pos <= pos + 2'd1;
                end else begin
                    tap_cnt <= tap_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: directed table, corner sequences, random traffic vs. timestamp model.
module tb_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] cfg_taps;
    logic       p_valid;
    logic       abort;
    logic       p_ready;
    logic [2:0] ctrl;
    logic       busy;
    logic       out_valid;
    logic [1:0] out_idx;
    logic       done;

    int tests = 0;
    int fails = 0;
    int ov_cnt = 0;
    int done_cnt = 0;

    // Reference model: a pass is described by tap count T, taps accepted n, and event timestamps.
    bit m_in_pass = 1'b0;
    int m_T = 1;
    int m_n = 0;
    int m_last = -100;
    int m_ov_cyc = -1;
    int m_ov_idx = 0;
    int cyc = 0;

    conv_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_taps (cfg_taps),
        .p_valid  (p_valid),
`ifdef CONV_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .p_ready  (p_ready),
        .ctrl     (ctrl),
        .busy     (busy),
        .out_valid(out_valid),
        .out_idx  (out_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [3:0] cfg;
        logic       pv;
        logic [2:0] e_ctrl;
        logic       e_rdy;
        logic       e_busy;
        logic       e_ov;
        logic [1:0] e_idx;
        logic       e_done;
    } vec_t;

    task automatic check_cnt(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_check_and_update();
        bit         acc_now, flush_now, done_now, ab_eff, e_ov;
        logic [1:0] e_pos, e_idx;
        logic [2:0] e_ctrl;
        logic [8:0] exp_v, act_v;
        acc_now   = m_in_pass && (m_n < 4 * m_T);
        flush_now = m_in_pass && (cyc == m_last + 1);
        done_now  = m_in_pass && (cyc == m_last + 2);
        ab_eff    = abort && (acc_now || flush_now);
        e_pos     = acc_now ? 2'(m_n / m_T) : 2'd0;
        e_ctrl    = (acc_now && !ab_eff) ? {p_valid, e_pos} : 3'b000;
        e_ov      = (m_ov_cyc == cyc) && !ab_eff;
        e_idx     = e_ov ? 2'(m_ov_idx) : 2'd0;
        exp_v = {e_ctrl, acc_now, acc_now || flush_now, e_ov, e_idx, done_now};
        act_v = {ctrl, p_ready, busy, out_valid, (e_ov ? out_idx : 2'd0), done};
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL model cyc=%0d got={ctrl,rdy,busy,ov,idx,done}=%b exp=%b", cyc, act_v, exp_v);
        end
        if (!m_in_pass) begin
            if (start) begin
                m_in_pass = 1'b1;
                m_T = (cfg_taps == 4'd0) ? 1 : int'(cfg_taps);
                m_n = 0;
                m_last = -100;
            end
        end else if (ab_eff) begin
            m_in_pass = 1'b0;
            m_ov_cyc = -1;
        end else if (done_now) begin
            m_in_pass = 1'b0;
        end else if (acc_now && p_valid) begin
            m_n++;
            if (m_n % m_T == 0) begin
                m_ov_cyc = cyc + 1;
                m_ov_idx = m_n / m_T - 1;
            end
            if (m_n == 4 * m_T) m_last = cyc;
        end
        cyc++;
    endtask

    task automatic step(input logic s, input logic [3:0] cfg, input logic pv, input logic ab);
        @(negedge clk);
        start = s;
        cfg_taps = cfg;
        p_valid = pv;
        abort = ab;
        #1;
        if (out_valid) ov_cnt++;
        if (done) done_cnt++;
        model_check_and_update();
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_cnt({name, "_async_outputs"}, int'({ctrl, p_ready, busy, out_valid, out_idx, done}), 0);
        m_in_pass = 1'b0;
        m_ov_cyc = -1;
        @(negedge clk);
        start = 1'b0;
        p_valid = 1'b0;
        abort = 1'b0;
        rst = 1'b1;
        cyc += 2;
    endtask

    task automatic clear_counts();
        ov_cnt = 0;
        done_cnt = 0;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{1'b0, 4'd0, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 4'd0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 4'd0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[4] = '{1'b0, 4'd0, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0};
        tbl[5] = '{1'b0, 4'd0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0};
        tbl[6] = '{1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
        tbl[7] = '{1'b1, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[8] = '{1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[9] = '{1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

        rst = 1'b0;
        start = 1'b0;
        cfg_taps = 4'd0;
        p_valid = 1'b1;
        abort = 1'b0;
        #1;
        check_cnt("reset_outputs", int'({ctrl, p_ready, busy, out_valid, out_idx, done}), 0);
        @(negedge clk);
        @(negedge clk);
        p_valid = 1'b0;
        rst = 1'b1;

        // Table: cfg_taps=0 acts as one tap, one stall, start pulse in DONE ignored.
        for (int unsigned i = 0; i < 10; i++) begin
            logic [8:0] exp_v, act_v;
            step(tbl[i].s, tbl[i].cfg, tbl[i].pv, 1'b0);
            exp_v = {tbl[i].e_ctrl, tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_ov,
                     (tbl[i].e_ov ? tbl[i].e_idx : 2'd0), tbl[i].e_done};
            act_v = {ctrl, p_ready, busy, out_valid, (tbl[i].e_ov ? out_idx : 2'd0), done};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL table_row%0d got=%b exp=%b", i, act_v, exp_v);
            end
        end

        // taps=3, no stalls: 12 taps, four results, one done.
        clear_counts();
        step(1'b1, 4'd3, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 12; i++) step(1'b0, 4'd3, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 4'd3, 1'b0, 1'b0);
        check_cnt("taps3_out_valid_count", ov_cnt, 4);
        check_cnt("taps3_done_count", done_cnt, 1);

        // taps=2 with p_valid toggling.
        clear_counts();
        step(1'b1, 4'd2, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'd2, ~i[0], 1'b0);
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 4'd2, 1'b0, 1'b0);
        check_cnt("toggle_out_valid_count", ov_cnt, 4);
        check_cnt("toggle_done_count", done_cnt, 1);

        // Reset after the 5th tap of a taps=4 pass, then a fresh full pass.
        clear_counts();
        step(1'b1, 4'd4, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 5; i++) step(1'b0, 4'd4, 1'b1, 1'b0);
        do_reset("midpass");
        for (int unsigned i = 0; i < 3; i++) step(1'b0, 4'd4, 1'b1, 1'b0);
        check_cnt("aborted_pass_done_count", done_cnt, 0);
        clear_counts();
        step(1'b1, 4'd4, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'd4, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 3; i++) step(1'b0, 4'd4, 1'b0, 1'b0);
        check_cnt("post_reset_out_valid_count", ov_cnt, 4);
        check_cnt("post_reset_done_count", done_cnt, 1);

        // Start pulses and cfg_taps changes during the pass are ignored.
        clear_counts();
        step(1'b1, 4'd2, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 8; i++) step(i[0], 4'(i + 5), 1'b1, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b0);
        step(1'b0, 4'd7, 1'b0, 1'b0);
        check_cnt("ignored_start_out_valid_count", ov_cnt, 4);
        check_cnt("ignored_start_done_count", done_cnt, 1);

`ifdef CONV_SEQ_ABORT_EN
        // Abort together with the 6th tap of a taps=2 pass.
        clear_counts();
        step(1'b1, 4'd2, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 5; i++) step(1'b0, 4'd2, 1'b1, 1'b0);
        step(1'b0, 4'd2, 1'b1, 1'b1);
        check_cnt("abort_ctrl", int'(ctrl), 0);
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 4'd2, 1'b1, 1'b0);
        check_cnt("abort_out_valid_count", ov_cnt, 2);
        check_cnt("abort_done_count", done_cnt, 0);
`endif

        // Random traffic against the model.
        for (int unsigned i = 0; i < 2500; i++) begin
            logic ab;
            ab = 1'b0;
`ifdef CONV_SEQ_ABORT_EN
            ab = ($urandom_range(0, 39) == 0);
`endif
            if (i % 700 == 350) do_reset("random");
            step(($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 3) != 0), ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
